// File: rtl/mac_burst_arbiter.sv
// Two-requester round-robin arbiter feeding a shared MAC datapath in fixed-length bursts.
// One burst is in flight at a time: grant, stream LEN operand pairs, wait for the MAC
// result, then hold the result until the consumer takes it.
module mac_burst_arbiter #(
  parameter int unsigned LEN = 8,
  parameter int unsigned OW  = 8,
  parameter int unsigned RW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [OW-1:0] req0_a,
  input  logic [OW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [OW-1:0] req1_a,
  input  logic [OW-1:0] req1_b,
  output logic          mac_vld,
  output logic [OW-1:0] mac_a,
  output logic [OW-1:0] mac_b,
  output logic          mac_last,
  input  logic          mac_res_vld,
  input  logic [RW-1:0] mac_res,
  output logic          res_valid,
  output logic          res_id,
  output logic [RW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          state_q;
  logic            grant_q;
  logic            ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            ready0_q;
  logic            ready1_q;
  logic            mac_vld_q;
  logic            mac_last_q;
  logic [OW-1:0]   mac_a_q;
  logic [OW-1:0]   mac_b_q;
  logic            res_valid_q;
  logic            res_id_q;
  logic [RW-1:0]   res_data_q;
  logic            busy_q;

  logic            grant_d;
  logic [CW-1:0]   cnt_d;
  logic            gnt_valid;
  logic            gnt_ready;
  logic [OW-1:0]   gnt_a;
  logic [OW-1:0]   gnt_b;
  logic            beat;

  // Arbitration decision, granted-requester mux and beat detection
  always_comb begin
    grant_d   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    cnt_d     = cnt_q + CW'(1);
    gnt_valid = grant_q ? req1_valid : req0_valid;
    gnt_ready = grant_q ? ready1_q   : ready0_q;
    gnt_a     = grant_q ? req1_a     : req0_a;
    gnt_b     = grant_q ? req1_b     : req0_b;
    beat      = (state_q == S_BURST) && gnt_valid && gnt_ready;
  end

  // Burst FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      mac_vld_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      mac_vld_q  <= 1'b0;
      mac_last_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_q  <= grant_d;
            ready0_q <= ~grant_d;
            ready1_q <= grant_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_BURST;
          end
        end
        S_BURST: begin
          if (beat) begin
            mac_vld_q <= 1'b1;
            mac_a_q   <= gnt_a;
            mac_b_q   <= gnt_b;
            if (cnt_q == LAST_BEAT) begin
              mac_last_q <= 1'b1;
              cnt_q      <= '0;
              ready0_q   <= 1'b0;
              ready1_q   <= 1'b0;
              state_q    <= S_WAIT;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        S_WAIT: begin
          if (mac_res_vld) begin
            res_data_q  <= mac_res;
            res_id_q    <= grant_q;
            res_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= ~grant_q;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign mac_vld    = mac_vld_q;
  assign mac_last   = mac_last_q;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mac_burst_arbiter.sv
// Bench for mac_burst_arbiter: burst-level reference model, bench-side MAC, directed
// scenarios with hand-computed results, then a randomized soak.
module tb_mac_burst_arbiter;

  localparam int unsigned LEN = 8;
  localparam int unsigned OW  = 8;
  localparam int unsigned RW  = 32;

  localparam int P_IDLE  = 0;
  localparam int P_BURST = 1;
  localparam int P_WAIT  = 2;
  localparam int P_OUT   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          mac_vld, mac_last;
  logic [OW-1:0] mac_a, mac_b;
  logic          mac_res_vld;
  logic [RW-1:0] mac_res;
  logic          res_valid, res_id;
  logic [RW-1:0] res_data;
  logic          res_ready;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  mac_burst_arbiter #(.LEN(LEN), .OW(OW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mac_vld(mac_vld), .mac_a(mac_a), .mac_b(mac_b), .mac_last(mac_last),
    .mac_res_vld(mac_res_vld), .mac_res(mac_res),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: burst phase, owner, beats taken, running product sum
  int            m_phase = P_IDLE;
  bit            m_owner = 1'b0;
  bit            m_ptr   = 1'b0;
  int            m_beats = 0;
  longint        m_sum   = 0;
  bit            m_beat  = 1'b0;
  bit            e_vld = 1'b0, e_last = 1'b0, e_rv = 1'b0, e_rid = 1'b0;
  logic [OW-1:0] e_a = '0, e_b = '0;
  logic [RW-1:0] e_rd = '0;

  // Bench-side MAC
  logic [RW-1:0] acc = '0;
  logic [RW-1:0] pres = '0;
  bit            pend = 1'b0;
  int            dly = 0;
  bit            spur_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit            gv;
    logic [OW-1:0] ga, gb;
    m_beat = 1'b0;
    if (rst) begin
      m_phase = P_IDLE; m_owner = 1'b0; m_ptr = 1'b0; m_beats = 0; m_sum = 0;
      e_vld = 1'b0; e_last = 1'b0; e_a = '0; e_b = '0;
      e_rv = 1'b0; e_rid = 1'b0; e_rd = '0;
      return;
    end
    e_vld  = 1'b0;
    e_last = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) m_owner = m_ptr;
          else                          m_owner = req1_valid;
          m_beats = 0;
          m_sum   = 0;
          m_phase = P_BURST;
        end
      end
      P_BURST: begin
        gv = m_owner ? req1_valid : req0_valid;
        ga = m_owner ? req1_a : req0_a;
        gb = m_owner ? req1_b : req0_b;
        if (gv) begin
          m_beat = 1'b1;
          e_vld  = 1'b1;
          e_a    = ga;
          e_b    = gb;
          m_sum  = m_sum + longint'(ga) * longint'(gb);
          m_beats++;
          if (m_beats == LEN) begin
            e_last  = 1'b1;
            m_phase = P_WAIT;
          end
        end
      end
      P_WAIT: begin
        if (mac_res_vld) begin
          e_rv    = 1'b1;
          e_rid   = m_owner;
          e_rd    = RW'(m_sum);
          m_phase = P_OUT;
        end
      end
      default: begin
        if (res_ready) begin
          e_rv    = 1'b0;
          m_ptr   = ~m_owner;
          m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("req0_ready", req0_ready, (m_phase == P_BURST) && (m_owner == 1'b0));
    chk("req1_ready", req1_ready, (m_phase == P_BURST) && (m_owner == 1'b1));
    chk("mac_vld", mac_vld, e_vld);
    chk("mac_last", mac_last, e_last);
    if (e_vld) begin
      chk("mac_a", mac_a, e_a);
      chk("mac_b", mac_b, e_b);
    end
    chk("busy", busy, m_phase != P_IDLE);
    chk("res_valid", res_valid, e_rv);
    chk("res_id", res_id, e_rid);
    chk("res_data", res_data, e_rd);
  endtask

  task automatic mac_env();
    mac_res_vld = 1'b0;
    mac_res     = '0;
    if (rst) begin
      acc  = '0;
      pend = 1'b0;
      return;
    end
    if (mac_vld === 1'b1) begin
      acc = acc + RW'(mac_a) * RW'(mac_b);
      if (mac_last === 1'b1) begin
        pend = 1'b1;
        pres = acc;
        acc  = '0;
        dly  = int'($urandom_range(0, 3));
      end
    end
    if (pend) begin
      if (dly == 0) begin
        mac_res_vld = 1'b1;
        mac_res     = pres;
        pend        = 1'b0;
      end else begin
        dly--;
      end
    end else if (spur_en && m_phase != P_WAIT && $urandom_range(0, 5) == 0) begin
      mac_res_vld = 1'b1;
      mac_res     = RW'($urandom);
    end
  endtask

  // One clock: model advance at the edge, compare 1 time unit later, then MAC reacts
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    mac_env();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output logic rid, output logic [RW-1:0] rdata,
                             output int r1hi);
    bit found = 1'b0;
    rid = 1'b0; rdata = '0; r1hi = 0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      if (res_valid === 1'b1) begin
        found = 1'b1;
        rid   = res_id;
        rdata = res_data;
      end else begin
        cycle();
        if (req1_ready === 1'b1) r1hi++;
      end
    end
    chk("result_timeout", found, 1'b1);
  endtask

  // req0 streams a = 1..LEN, b = 2; optional valid gap and result backpressure
  task automatic burst_req0(input int gap_after, input int gap_len, input int hold);
    int            a_idx = 1;
    int            gap_left = 0;
    int            vcnt = 0, last_at = 0, first_t = -1, last_t = -1, cyc = 0, r1hi;
    logic          rid;
    logic [RW-1:0] rdata;
    req0_a = OW'(1); req0_b = OW'(2); req0_valid = 1'b1;
    req1_valid = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 60 && last_at == 0; i++) begin
      cycle();
      cyc++;
      if (mac_vld === 1'b1) begin
        vcnt++;
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
        if (mac_last === 1'b1) last_at = vcnt;
      end
      if (m_beat) begin
        a_idx++;
        if (a_idx - 1 == gap_after) gap_left = gap_len;
      end
      if (gap_left > 0) begin
        req0_valid = 1'b0;
        gap_left--;
      end else begin
        req0_valid = (a_idx <= LEN);
      end
      req0_a = OW'(a_idx);
    end
    chk("burst_vld_count", 64'(vcnt), 64'd8);
    chk("burst_last_beat", 64'(last_at), 64'd8);
    chk("burst_span", 64'(last_t - first_t + 1), 64'(8 + gap_len));
    wait_result(20, rid, rdata, r1hi);
    for (int h = 0; h < hold; h++) begin
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_data", res_data, 64'd72);
      chk("bp_req0_ready", req0_ready, 1'b0);
      cycle();
    end
    chk("burst_res_data", res_data, 64'd72);
    chk("burst_res_id", res_id, 1'b0);
    res_ready = 1'b1;
    cycle();
    chk("burst_released", res_valid, 1'b0);
    res_ready = 1'b0;
  endtask

  initial begin
    logic          rid;
    logic [RW-1:0] rdata;
    int            r1hi, nb;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    mac_res_vld = 1'b0; mac_res = '0;
    cycle();
    cycle();
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_mac_vld", mac_vld, 1'b0);
    chk("rst_mac_last", mac_last, 1'b0);
    chk("rst_mac_a", mac_a, 64'd0);
    chk("rst_mac_b", mac_b, 64'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Single continuous burst, then one with a 3-cycle gap, then result backpressure
    burst_req0(0, 0, 0);
    do_reset();
    burst_req0(4, 3, 0);
    do_reset();
    burst_req0(0, 0, 4);

    // Contention straight out of reset: req0 first, then req1
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    req0_a = OW'($urandom); req0_b = OW'($urandom);
    req1_a = OW'($urandom); req1_b = OW'($urandom);
    wait_result(40, rid, rdata, r1hi);
    chk("cont_first_id", rid, 1'b0);
    chk("cont_req1_ready_cycles", 64'(r1hi), 64'd0);
    cycle();
    wait_result(40, rid, rdata, r1hi);
    chk("cont_second_id", rid, 1'b1);

    // Round robin: req0 alone completes, then both valid
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b1;
    wait_result(40, rid, rdata, r1hi);
    chk("rr_first_id", rid, 1'b0);
    req1_valid = 1'b1;
    cycle();
    wait_result(40, rid, rdata, r1hi);
    chk("rr_second_id", rid, 1'b1);

    // Reset after beat 5
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 30 && nb < 5; i++) begin
      cycle();
      if (m_beat) nb++;
      req0_a = OW'($urandom); req0_b = OW'($urandom);
    end
    chk("rb_beats", 64'(nb), 64'd5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rb_req0_ready", req0_ready, 1'b0);
    chk("rb_mac_vld", mac_vld, 1'b0);
    chk("rb_mac_last", mac_last, 1'b0);
    chk("rb_mac_a", mac_a, 64'd0);
    chk("rb_res_valid", res_valid, 1'b0);
    chk("rb_res_data", res_data, 64'd0);
    chk("rb_busy", busy, 1'b0);
    req0_valid = 1'b0;
    mac_res_vld = 1'b1; mac_res = RW'(32'h1234);
    cycle();
    chk("rb_late_res_ignored", res_valid, 1'b0);
    chk("rb_idle", busy, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle();
    chk("rb_grant_req0", req0_ready, 1'b1);
    chk("rb_no_req1", req1_ready, 1'b0);

    // Randomized soak
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      rst        = ($urandom_range(0, 599) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = OW'($urandom); req0_b = OW'($urandom);
      req1_a = OW'($urandom); req1_b = OW'($urandom);
      res_ready = ($urandom_range(0, 1) == 1);
    end
    spur_en = 1'b0;
    rst = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_burst_arbiter.md
MAC_BURST_ARBITER -- requirements
Module: mac_burst_arbiter

Interface
REQ-001 Parameter LEN, default 8: operand pairs (beats) per burst, range 2..16.
REQ-002 Parameter OW, default 8: operand width.
REQ-003 Parameter RW, default 32: MAC result width.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req0_valid / req1_valid  in  1  requester n offers an operand pair.
REQ-008 req0_ready / req1_ready  out  1  arbiter accepts requester n's pair this cycle.
REQ-009 req0_a, req0_b / req1_a, req1_b  in  OW  unsigned operands of requester n.
REQ-010 mac_vld  out  1  operand pair valid to the shared MAC datapath.
REQ-011 mac_a, mac_b  out  OW  operands to the MAC.
REQ-012 mac_last  out  1  qualifies the final beat of a burst.
REQ-013 mac_res_vld  in  1  MAC reports burst result.
REQ-014 mac_res  in  RW  accumulated burst result from the MAC.
REQ-015 res_valid  out  1  result available to the owning requester.
REQ-016 res_id  out  1  owner of res_data (0 or 1).
REQ-017 res_data  out  RW  burst result.
REQ-018 res_ready  in  1  consumer accepts result.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, BURST, WAIT, OUT.
REQ-021 IDLE: if any reqN_valid, register grant and enter BURST next cycle; if none, stay.
REQ-022 Arbitration: single requester valid -> grant it; both valid -> grant the one not served last (round-robin pointer); pointer after reset favours requester 0.
REQ-023 Grant held for a full burst of LEN beats; no preemption.
REQ-024 BURST: reqG_ready = 1 for the granted requester only; the other's ready = 0 in every state.
REQ-025 Beat = reqG_valid & reqG_ready; beat counter counts 0..LEN-1; requester valid gaps stall the burst, counter holds.
REQ-026 Beat accepted in cycle t -> mac_vld = 1 with registered mac_a/mac_b in cycle t+1; mac_vld = 0 in cycles without a beat.
REQ-027 mac_last = 1 with the mac_vld of beat LEN-1 only; FSM enters WAIT the cycle after that beat is accepted; ready drops at the same time.
REQ-028 WAIT: on mac_res_vld capture mac_res into res_data, enter OUT; mac_res_vld in any other state ignored.
REQ-029 OUT: res_valid = 1, res_id = granted requester; res_data and res_id stable while res_ready = 0.
REQ-030 OUT with res_ready = 1 at cycle t: res_valid = 0 at t+1, pointer toggles to the other requester, state IDLE at t+1; next grant earliest in BURST at t+2.
REQ-031 No new burst begins before OUT handshake completes (strictly one burst in flight).
REQ-032 Widths: operands passed unmodified; res_data is mac_res with no truncation or extension.
REQ-033 Counter wrap: counter returns to 0 on entering WAIT; never exceeds LEN-1.

Reset
REQ-034 rst = 1 at a clock edge: state IDLE, counter 0, pointer -> requester 0, in-flight burst discarded.
REQ-035 Reset values: req0_ready = req1_ready = 0, mac_vld = 0, mac_last = 0, mac_a = mac_b = 0, res_valid = 0, res_id = 0, res_data = 0, busy = 0.
REQ-036 Reset mid-burst or during OUT: all outputs at reset values the cycle after; no partial result emitted.

Verification
REQ-037 Single burst: req0 supplies a = 1..8, b = 2 continuously -> mac_vld 8 consecutive cycles, mac_last on the 8th; bench MAC returns 72 -> res_valid, res_id = 0, res_data = 72.
REQ-038 Contention: both valid from the first cycle after reset -> req0 served first, req1 ready = 0 throughout; after OUT handshake req1 granted, res_id = 1.
REQ-039 Round-robin: only req0 completes a burst, then both valid -> req1 granted.
REQ-040 Gaps: req0 deasserts valid for 3 cycles after beat 4 -> mac_vld = 0 for those cycles, counter holds, mac_last still on the 8th beat.
REQ-041 Backpressure: res_ready = 0 for 4 cycles in OUT -> res_valid held, res_data stable, no ready to either requester; result released on first res_ready = 1.
REQ-042 Reset at beat 5 -> next cycle IDLE, all outputs reset; a subsequent mac_res_vld is ignored; next grant goes to req0.
